// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared types and defaults for the CPU memory-port arbiter.
//   - DEF_ADDR_W / DEF_DATA_W : default address and data widths
//   - arb_state_e             : arbiter FSM states
//   - gnt_src_e               : which requester owns the current access
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_src_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// ---------------------------------------------------------------------------
// mem_arb_watchdog
// Wait-state counter that flags a memory access which never acknowledges.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : forces the count back to zero (used whenever no access waits)
//   enable    : counts one wait-state cycle per clock
//   expired   : high in the TIMEOUT-th consecutive enabled cycle
// ---------------------------------------------------------------------------
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    // The count starts at zero in the first wait cycle, so the expiry compare
    // against TIMEOUT-1 fires on exactly the TIMEOUT-th wait cycle.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

    // Count wait cycles; hold once expired so the owner has a cycle to react.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one multi-cycle memory port between instruction fetch (IF) and the
// data-memory stage (DM). Data wins arbitration unless IF has already been
// passed over STARVE_LIMIT times in a row. Each access is a req/ack handshake
// with memory followed by a one-cycle ready pulse to the winning requester.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   if_req_i/if_addr_i    : instruction read request and address
//   if_flush_i            : discards an in-flight IF access
//   if_rdata_o/if_ready_o : fetched word and its completion pulse
//   if_stall_o            : IF request not yet completed
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : data request
//   dm_rdata_o/dm_ready_o : read data and its completion pulse
//   dm_stall_o            : data request not yet completed
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : backing memory request
//   mem_ack_i/mem_rdata_i : memory completion and read data
//   err_o                 : sticky timeout flag
// ---------------------------------------------------------------------------
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_e     state;
    logic [SCW-1:0] starve_cnt;
    logic           drop_q;
    logic           starve_hit;
    logic           grant_dm;
    logic           grant_if;
    gnt_src_e       gnt_src;
    logic           flushed;
    logic           wd_enable;
    logic           wd_clear;
    logic           wd_expired;

    // IF gets forced through once data has won STARVE_LIMIT times while IF waited.
    assign starve_hit = if_req_i && (starve_cnt == SCW'(STARVE_LIMIT));
    assign grant_dm   = dm_req_i && !starve_hit;
    assign grant_if   = if_req_i && !grant_dm;
    assign gnt_src    = grant_dm ? GNT_DM : GNT_IF;

    // A flush in the ack cycle itself counts, so the access is dropped either way.
    assign flushed    = drop_q || if_flush_i;

    assign wd_enable  = (state == D_WAIT) || (state == I_WAIT);
    assign wd_clear   = !wd_enable;

    assign if_stall_o = if_req_i & ~if_ready_o;
    assign dm_stall_o = dm_req_i & ~dm_ready_o;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Arbiter FSM: IDLE arbitrates and launches, *_WAIT holds the memory
    // request until ack or timeout, RESP carries the one-cycle ready pulse.
    // All outputs are registered here; ready pulses default low every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ready_o  <= 1'b0;
            dm_ready_o  <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            err_o       <= 1'b0;
            starve_cnt  <= '0;
            drop_q      <= 1'b0;
        end else begin
            if_ready_o <= 1'b0;
            dm_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (grant_dm || grant_if) begin
                        mem_req_o <= 1'b1;
                        if (gnt_src == GNT_DM) begin
                            mem_we_o    <= dm_we_i;
                            mem_addr_o  <= dm_addr_i;
                            mem_wdata_o <= dm_wdata_i;
                            if (!if_req_i) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt != SCW'(STARVE_LIMIT)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                            state <= D_WAIT;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                            starve_cnt  <= '0;
                            state       <= I_WAIT;
                        end
                    end
                end
                D_WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                        dm_ready_o <= 1'b1;
                        state      <= RESP;
                    end else if (wd_expired) begin
                        mem_req_o  <= 1'b0;
                        err_o      <= 1'b1;
                        dm_rdata_o <= '0;
                        dm_ready_o <= 1'b1;
                        state      <= RESP;
                    end
                end
                I_WAIT: begin
                    if (mem_ack_i || wd_expired) begin
                        mem_req_o <= 1'b0;
                        drop_q    <= 1'b0;
                        if (!mem_ack_i) begin
                            err_o <= 1'b1;
                        end
                        if (flushed) begin
                            state <= IDLE;
                        end else begin
                            if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                            if_ready_o <= 1'b1;
                            state      <= RESP;
                        end
                    end else begin
                        drop_q <= flushed;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
